// File: rtl/relu_sched.sv
// relu_sched: credit-gated issue of one frame into a fixed-latency ReLU, buffered valid/ready output; `RELU_SCHED_ZERO_CNT_EN adds a zero-result counter
module relu_sched #(
    parameter int WIDTH      = 32,
    parameter int LAT        = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        frame_len,
    output logic                    busy,
    output logic                    done,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_sum,
    input  logic signed [WIDTH-1:0] in_sum1,
    input  logic                    in_s2,
    output logic signed [WIDTH-1:0] relu_sum,
    output logic signed [WIDTH-1:0] relu_sum1,
    output logic                    relu_s2,
    input  logic signed [WIDTH-1:0] relu_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic [LEN_W-1:0]        zero_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(LAT + 2);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [LEN_W-1:0] len, issued;
    logic [LAT:0] tag_v, tag_l;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_l;
    logic [AW-1:0] rptr, wptr;
    logic [CW-1:0] count;
    logic [IW-1:0] inflight;
    logic accept, push, pop, last_acc;
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= LAT; i++) inflight = inflight + IW'(tag_v[i]);
    end
    // credit counts results already headed for the FIFO so the non-stallable pipe never overruns it
    assign in_ready  = state == ISSUE && issued < len && (32'(count) + 32'(inflight) < FIFO_DEPTH);
    assign accept    = in_valid && in_ready;
    assign last_acc  = issued == len - 1'b1;
    assign push      = tag_v[LAT];
    assign out_valid = count != '0;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rptr] : '0;
    assign out_last  = out_valid && mem_l[rptr];
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? (frame_len == '0 ? DONE : ISSUE) : IDLE;
            ISSUE:   state_nx = accept && last_acc ? DRAIN : ISSUE;
            DRAIN:   state_nx = inflight == '0 && count == '0 ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            len       <= '0;
            issued    <= '0;
            tag_v     <= '0;
            tag_l     <= '0;
            relu_sum  <= '0;
            relu_sum1 <= '0;
            relu_s2   <= 1'b0;
            rptr      <= '0;
            wptr      <= '0;
            count     <= '0;
            mem_l     <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                len    <= frame_len;
                issued <= '0;
            end
            if (accept) begin
                relu_sum  <= in_sum;
                relu_sum1 <= in_sum1;
                relu_s2   <= in_s2;
                issued    <= issued + 1'b1;
            end
            tag_v <= {tag_v[LAT-1:0], accept};
            tag_l <= {tag_l[LAT-1:0], accept && last_acc};
            if (push) begin
                mem[wptr]   <= relu_out;
                mem_l[wptr] <= tag_l[LAT];
                wptr        <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
`ifdef RELU_SCHED_ZERO_CNT_EN
    logic [LEN_W-1:0] zc;
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) zc <= '0;
        else if (push && relu_out == '0 && zc != '1) zc <= zc + 1'b1;
    end
    assign zero_cnt = zc;
`else
    assign zero_cnt = '0;
`endif
endmodule
